// File: rtl/ram_dma_engine.sv
// Block-transfer initiator for RAM port B: word-by-word copy (RAM to RAM) or
// fill (constant to RAM). Every output is registered; mem_addr is held across
// the read-capture cycle because the RAM bank mux selects on the live address.
module ram_dma_engine #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    typedef enum logic [2:0] {
        StIdle,
        StRdIssue,
        StRdCapture,
        StWrite,
        StDone
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CntOne  = (ADDR_WIDTH + 1)'(1);

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  we_q, we_d;

    // State, working registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            fill_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            fill_q  <= fill_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
        end
    end

    // Next state plus the output values to present in the next cycle.
    // src_q/dst_q always hold the next address to use; rem_q counts words not yet written.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        fill_d  = fill_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d = mode;
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    rem_d  = length;
                    fill_d = fill_value;
                    busy_d = 1'b1;
                    if (length == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else if (!mode) begin
                        state_d = StRdIssue;
                        addr_d  = src_addr;
                    end else begin
                        state_d = StWrite;
                        addr_d  = dst_addr;
                        data_d  = fill_value;
                        we_d    = 1'b1;
                        dst_d   = dst_addr + AddrOne;
                        rem_d   = length - CntOne;
                    end
                end
            end
            StRdIssue: begin
                // Address stays on src so the bank mux still points at it next cycle.
                state_d = StRdCapture;
            end
            StRdCapture: begin
                state_d = StWrite;
                addr_d  = dst_q;
                data_d  = mem_q;
                we_d    = 1'b1;
                src_d   = src_q + AddrOne;
                dst_d   = dst_q + AddrOne;
                rem_d   = rem_q - CntOne;
            end
            StWrite: begin
                if (rem_q != '0) begin
                    if (mode_q) begin
                        addr_d = dst_q;
                        data_d = fill_q;
                        we_d   = 1'b1;
                        dst_d  = dst_q + AddrOne;
                        rem_d  = rem_q - CntOne;
                    end else begin
                        state_d = StRdIssue;
                        addr_d  = src_q;
                    end
                end else begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign mem_addr = addr_q;
    assign mem_data = data_q;
    assign mem_we   = we_q;

endmodule

// File: tb/tb_ram_dma_engine.sv
// Bench for ram_dma_engine: a two-bank RAM model on port B, a word-level
// reference memory, and a scoreboard of expected writes/done pulses with cycle stamps.
module tb_ram_dma_engine;

    localparam int DW = 16;
    localparam int AW = 10;

    typedef struct packed {
        logic          is_done;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW:0]   length = '0;
    logic [DW-1:0] fill_value = '0;
    logic          busy, done, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data, mem_q;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    ev_t sb[$];
    ev_t mon_e;
    logic [DW-1:0] model_mem [1024];

    // RAM model: synchronous write, registered read per bank, bank mux on live address.
    logic [DW-1:0] ram [1024];
    logic [DW-1:0] q_lo, q_hi;
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_data;
        else if (bd_we) ram[bd_addr] <= bd_data;
        q_lo <= ram[{1'b0, mem_addr[AW-2:0]}];
        q_hi <= ram[{1'b1, mem_addr[AW-2:0]}];
    end
    assign mem_q = mem_addr[AW-1] ? q_hi : q_lo;

    ram_dma_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .fill_value (fill_value),
        .busy       (busy),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .mem_q      (mem_q)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write or done pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (!reset && (mem_we || done)) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {30'd0, mem_we, done}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("event_kind", {31'd0, done}, {31'd0, mon_e.is_done});
                if (!mon_e.is_done) begin
                    check("wr_addr", {22'd0, mem_addr}, {22'd0, mon_e.addr});
                    check("wr_data", {16'd0, mem_data}, {16'd0, mon_e.data});
                end
                check("event_cycle", cyc, mon_e.cyc);
                check("busy_during_xfer", {31'd0, busy}, 32'd1);
            end
        end
    end

    task automatic poke(input int a, input logic [DW-1:0] d);
        @(negedge clk); #1;
        bd_we = 1'b1;
        bd_addr = a[AW-1:0];
        bd_data = d;
        model_mem[a] = d;
        @(negedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Issue a command; the reference applies it word by word in ascending order
    // and records the expected write/done cycles relative to the accepting edge E0.
    // cut limits how many words are expected (for a transfer that gets reset).
    task automatic issue(input bit m, input int s, input int d, input int n,
                         input logic [DW-1:0] f, input int cut);
        int e0;
        int a;
        ev_t e;
        logic [DW-1:0] w;
        @(negedge clk); #1;
        mode = m;
        src_addr = s[AW-1:0];
        dst_addr = d[AW-1:0];
        length = n[AW:0];
        fill_value = f;
        start = 1'b1;
        e0 = cyc + 1;
        for (int k = 0; k < n && k < cut; k++) begin
            a = (d + k) & 1023;
            w = m ? f : model_mem[(s + k) & 1023];
            model_mem[a] = w;
            e.is_done = 1'b0;
            e.addr = a[AW-1:0];
            e.data = w;
            e.cyc = m ? e0 + k : e0 + 3 * k + 2;
            sb.push_back(e);
        end
        if (cut >= n) begin
            e.is_done = 1'b1;
            e.addr = '0;
            e.data = '0;
            e.cyc = e0 + ((n == 0) ? 0 : (m ? n : 3 * n));
            sb.push_back(e);
        end
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    // Wait for the scoreboard to drain; optionally pulse start with junk while busy.
    task automatic wait_done(input int budget, input bit inject);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (sb.size() == 0) break;
            if (inject && busy && $urandom_range(3) == 0) begin
                start = 1'b1;
                mode = 1'($urandom);
                src_addr = AW'($urandom);
                dst_addr = AW'($urandom);
                length = (AW + 1)'($urandom_range(1, 50));
                fill_value = DW'($urandom);
            end
        end
        start = 1'b0;
        if (sb.size() != 0) begin
            check("completion_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);
    endtask

    task automatic compare_mem(input string name);
        int bad = 0;
        for (int i = 0; i < 1024; i++) if (ram[i] !== model_mem[i]) bad++;
        check(name, bad, 0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        for (int i = 0; i < 1024; i++) poke(i, DW'($urandom));
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", {22'd0, mem_addr}, 32'd0);
        check("rst_data", {16'd0, mem_data}, 32'd0);
        #1 reset = 1'b0;

        issue(1'b1, 0, 'h1FE, 4, 16'hA5A5, 2000);
        wait_done(20, 1'b0);
        compare_mem("fill_bank_cross_mem");

        for (int i = 0; i < 4; i++) poke('h10 + i, DW'('h1111 * (i + 1)));
        issue(1'b0, 'h10, 'h210, 4, 16'h0, 2000);
        wait_done(30, 1'b0);
        compare_mem("copy_mem");

        issue(1'b1, 0, 'h3FF, 3, 16'h00FF, 2000);
        wait_done(20, 1'b0);
        compare_mem("wrap_mem");

        issue(1'b1, 0, 'h055, 0, 16'hBEEF, 2000);
        wait_done(10, 1'b0);
        compare_mem("zero_len_mem");

        issue(1'b1, 0, 'h080, 100, 16'h5A5A, 2000);
        wait_done(400, 1'b1);
        compare_mem("busy_start_mem");

        poke('h100, 16'h0001);
        poke('h101, 16'h0002);
        issue(1'b0, 'h100, 'h101, 2, 16'h0, 2000);
        wait_done(30, 1'b0);
        check("overlap_101", {16'd0, ram['h101]}, 32'h0001);
        check("overlap_102", {16'd0, ram['h102]}, 32'h0001);
        compare_mem("overlap_mem");

        // Reset while the second fill word is on the port.
        issue(1'b1, 0, 'h300, 5, 16'hC3C3, 2);
        @(negedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_we", {31'd0, mem_we}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_scoreboard", sb.size(), 0);
        compare_mem("rst_mid_mem");
        issue(1'b1, 0, 'h302, 2, 16'h1234, 2000);
        wait_done(20, 1'b0);
        compare_mem("after_reset_mem");

        for (int t = 0; t < 25; t++) begin
            n = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(1, 40));
            issue(1'($urandom), int'($urandom_range(1023)), int'($urandom_range(1023)), n,
                  DW'($urandom), 2000);
            wait_done(3 * n + 20, 1'($urandom));
            compare_mem("random_mem");
        end

        issue(1'b0, 7, 0, 1024, 16'h0, 2000);
        wait_done(3200, 1'b0);
        compare_mem("copy_full_mem");
        issue(1'b1, 0, 'h123, 1024, 16'h7E7E, 2000);
        wait_done(1100, 1'b0);
        compare_mem("fill_full_mem");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_dma_engine.md
# ram_dma_engine

Block-transfer initiator that drives one port of the two-bank 1024x16 dual-port data RAM, performing word-by-word copy (RAM to RAM) or fill (constant to RAM) on command. It sits between the processor's control registers and RAM port B, freeing the datapath from load/store loops. It is the reading and writing side of the RAM port protocol: synchronous write, one-cycle registered read, and a combinational bank-select mux on the current address.

## Interface
- DATA_WIDTH, 16, word width; equals the RAM data width
- ADDR_WIDTH, 10, word address width; MSB is the RAM bank select
- clk  in  1  rising-edge clock shared with the RAM
- reset  in  1  synchronous, active-high
- start  in  1  command strobe; accepted only in IDLE
- mode  in  1  0 = copy, 1 = fill
- src_addr  in  ADDR_WIDTH  copy source base address; ignored for fill
- dst_addr  in  ADDR_WIDTH  destination base address
- length  in  ADDR_WIDTH+1  word count, 0..1024
- fill_value  in  DATA_WIDTH  fill word
- busy  out  1  high from the cycle after acceptance through the DONE cycle
- done  out  1  one-cycle completion pulse
- mem_addr  out  ADDR_WIDTH  to RAM addr_b
- mem_data  out  DATA_WIDTH  to RAM data_b
- mem_we  out  1  to RAM we_b
- mem_q  in  DATA_WIDTH  from RAM q_b_out

## Operation
- All outputs are registered. The reset value of busy, done, mem_addr, mem_data and mem_we is 0. The state resets to IDLE.
- On acceptance, latch mode, src, dst, length and fill_value into working registers. Later input changes have no effect.
- States:
  - IDLE
  - RD_ISSUE
  - RD_CAPTURE
  - WRITE
  - DONE
- Transitions:
  - IDLE: start with length=0 goes to DONE. Start with copy goes to RD_ISSUE. Start with fill goes to WRITE.
  - RD_ISSUE goes to RD_CAPTURE.
  - RD_CAPTURE goes to WRITE.
  - WRITE: if words remain, copy goes to RD_ISSUE and fill stays in WRITE. If no words remain, go to DONE.
  - DONE goes to IDLE.
- Copy, per word:
  - RD_ISSUE: mem_addr = src, mem_we = 0.
  - RD_CAPTURE: mem_addr stays at src. This is mandatory because the RAM's bank mux selects on the current address. Capture mem_q at the end of this cycle.
  - WRITE: mem_addr = dst, mem_data = captured word, mem_we = 1.
  - Then increment src and dst.
- Fill, per word: WRITE with mem_addr = dst, mem_data = fill_value, mem_we = 1. Then increment dst.
- Addresses increment modulo 2^ADDR_WIDTH, so 1023 wraps to 0. Crossing the bank boundary (511 to 512) needs no special handling.
- The remaining-word counter is ADDR_WIDTH+1 bits. It decrements on each WRITE, and length=1024 transfers the whole memory.
- Copy is strictly ascending. Overlapping ranges with dst > src re-read already-written words; this behaviour is defined, not an error.
- mem_we is high only in WRITE. In all other states it is 0, and mem_data holds its last value.
- start while busy is ignored, including in the DONE cycle.
- Reset mid-transfer: at the reset edge mem_we, busy and done go to 0 and the state goes to IDLE. No further writes occur. Words already written stay written.

## Timing
- Edge E0 samples start in IDLE. busy=1 from the cycle after E0.
- Copy of N words: word k (k=0..N-1) is written at edge E(3k+3). DONE occupies the cycle after E(3N), with done=1 and busy=1. busy=0 after E(3N+1). Throughput is 3 cycles per word.
- Fill of N words: mem_we is high for N consecutive cycles, starting the cycle after E0. DONE occupies the cycle after E(N).
- length=0: DONE occupies the cycle after E0. mem_we never asserts.
- Read latency: mem_q is valid in the RD_CAPTURE cycle, one cycle after the address is presented.

## Test plan
- Fill: dst=0x1FE, length=4, fill=0xA5A5. Required: writes to 0x1FE, 0x1FF, 0x200, 0x201 on 4 consecutive cycles; done pulses 1 cycle after the last write. Read back to confirm both banks.
- Copy: preload 0x010..0x013 with 0x1111..0x4444, then copy src=0x010, dst=0x210, length=4. Required: 0x210..0x213 hold 0x1111..0x4444; done pulses on the cycle after the 12th post-start edge.
- Wrap: fill dst=0x3FF, length=3, fill=0x00FF. Required: addresses 0x3FF, 0x000 and 0x001 are written; 0x002 is unchanged.
- Zero length and busy start: start with length=0. Required: done asserts the next cycle with no mem_we. Then, during a 100-word fill, pulse start with different operands. Required: ignored; the original transfer completes unchanged.
- Overlap: preload 0x100=0x0001 and 0x101=0x0002, then copy src=0x100, dst=0x101, length=2. Required: 0x101=0x0001 and 0x102=0x0001.
- Reset: assert reset during word 2 of a 5-word fill. Required: mem_we=0, busy=0 and done=0 after the edge; the words already written remain; the rest of the destination is untouched; a new command is accepted afterward.
